// File: rtl/seq_detector_prog.sv
// seq_detector_prog: run-time programmable serial pattern detector with overlap mode and saturating match counter
module seq_detector_prog #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN + 1),
  parameter int                 CNT_W       = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('b0111),
  parameter int                 DEF_LEN     = 4,
  parameter logic               DEF_OVERLAP = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               d,
  input  logic               en,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               y,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);
  logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, win, mask;
  logic [LEN_W-1:0]   len_q, len_d, fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovl_q, ovl_d, err_q, err_d, shift;
  always_comb begin
    win    = {hist_q[MAX_LEN-2:0], d};
    mask   = ~({MAX_LEN{1'b1}} << len_q);
    // fill+1 >= len rather than fill >= len-1 so len=0 cannot wrap
    y      = en & ~cfg_load & ~err_q & ~reset
           & ((LEN_W+1)'(fill_q) + 1'b1 >= (LEN_W+1)'(len_q))
           & ~|((win ^ pat_q) & mask);
    shift  = en & ~cfg_load & ~err_q;
    hist_d = shift ? win : hist_q;
    fill_d = cfg_load | (shift & y & ~ovl_q) ? '0
           : shift & (fill_q != LEN_W'(MAX_LEN)) ? fill_q + 1'b1 : fill_q;
    pat_d  = cfg_load ? cfg_pattern : pat_q;
    len_d  = cfg_load ? cfg_len : len_q;
    ovl_d  = cfg_load ? cfg_overlap : ovl_q;
    err_d  = cfg_load ? (cfg_len == '0) | (cfg_len > LEN_W'(MAX_LEN)) : err_q;
    cnt_d  = cnt_clr ? '0 : (y & ~&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      ovl_q  <= DEF_OVERLAP;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end
  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;
endmodule

// File: tb/tb_seq_detector_prog.sv
// tb_seq_detector_prog: directed scenarios plus randomized run against a queue-based reference model
module tb_seq_detector_prog;
  logic       clk = 0, reset = 1, d = 0, en = 0, cfg_load = 0, cfg_overlap = 0, cnt_clr = 0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       y, cfg_err, y2, err2;
  logic [7:0] match_cnt;
  logic [1:0] cnt2;
  int n_cmp = 0, n_bad = 0;
  bit [7:0] m_pat;
  int m_len, m_cnt, m_cnt2;
  bit m_ovl, m_err, exp_y, obs_y, obs_y2;
  bit m_q[$];

  seq_detector_prog u_dut (
    .clk(clk), .reset(reset), .d(d), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y), .match_cnt(match_cnt), .cfg_err(cfg_err));
  seq_detector_prog #(.CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .d(d), .en(en), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cnt_clr(cnt_clr), .y(y2), .match_cnt(cnt2), .cfg_err(err2));

  always #5 clk = ~clk;

  // Model keeps only the bits accepted since the last history restart.
  function automatic bit model_y();
    if (!en || cfg_load || m_err || reset) return 0;
    if (m_q.size() < m_len - 1) return 0;
    for (int j = 0; j < m_len - 1; j++)
      if (m_q[m_q.size() - (m_len - 1) + j] != m_pat[m_len-1-j]) return 0;
    return d == m_pat[0];
  endfunction

  function automatic void model_update();
    if (reset) begin
      m_pat = 8'b0111; m_len = 4; m_ovl = 0; m_err = 0; m_cnt = 0; m_cnt2 = 0;
      m_q.delete();
    end else begin
      if (cfg_load) begin
        m_pat = cfg_pattern; m_len = int'(cfg_len); m_ovl = cfg_overlap;
        m_err = (cfg_len == 0) || (cfg_len > 8);
        m_q.delete();
      end else if (en && !m_err) begin
        if (exp_y && !m_ovl) m_q.delete();
        else begin
          m_q.push_back(d);
          if (m_q.size() > 8) void'(m_q.pop_front());
        end
      end
      m_cnt  = cnt_clr ? 0 : (exp_y && m_cnt < 255) ? m_cnt + 1 : m_cnt;
      m_cnt2 = cnt_clr ? 0 : (exp_y && m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
    end
  endfunction

  task automatic step(input bit r, input bit dv, input bit ev, input bit lv, input bit cv);
    @(negedge clk);
    reset = r; d = dv; en = ev; cfg_load = lv; cnt_clr = cv;
    #1;
    exp_y = model_y(); obs_y = y; obs_y2 = y2;
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 0, 0);
    n_cmp++; if (obs_y !== 1'b0) begin n_bad++; $display("FAIL reset_y: got %b want 0", obs_y); end
    n_cmp++; if (match_cnt !== 8'd0 || cnt2 !== 2'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", match_cnt, cnt2); end
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", cfg_err); end
  endtask

  task automatic test_default();
    bit [7:0] s = 8'b0111_0111;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, s[7-i], 1, 0, 0);
      n_cmp++; if (obs_y !== (i == 3 || i == 7)) begin n_bad++; $display("FAIL default_y[%0d]: got %b want %b", i, obs_y, (i == 3 || i == 7)); end
    end
    n_cmp++; if (match_cnt !== 8'd2) begin n_bad++; $display("FAIL default_cnt: got %0d want 2", match_cnt); end
  endtask

  task automatic test_overlap();
    bit [4:0] s = 5'b10101;
    step(1, 0, 0, 0, 0);
    for (int o = 1; o >= 0; o--) begin
      cfg_pattern = 8'b101; cfg_len = 3; cfg_overlap = o[0];
      step(0, 1, 1, 1, 0);
      n_cmp++; if (obs_y !== 1'b0) begin n_bad++; $display("FAIL load_y: got %b want 0", obs_y); end
      for (int i = 0; i < 5; i++) begin
        step(0, s[4-i], 1, 0, 0);
        n_cmp++; if (obs_y !== (i == 2 || (o == 1 && i == 4))) begin n_bad++; $display("FAIL overlap%0d_y[%0d]: got %b want %b", o, i, obs_y, (i == 2 || (o == 1 && i == 4))); end
      end
    end
  endtask

  task automatic test_gaps();
    bit [3:0] s = 4'b0111;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, s[3-i], 1, 0, 0);
      n_cmp++; if (obs_y !== (i == 3)) begin n_bad++; $display("FAIL gap_valid_y[%0d]: got %b want %b", i, obs_y, (i == 3)); end
      step(0, 1'($urandom), 0, 0, 0);
      n_cmp++; if (obs_y !== 1'b0) begin n_bad++; $display("FAIL gap_bubble_y[%0d]: got %b want 0", i, obs_y); end
    end
    n_cmp++; if (match_cnt !== 8'd1) begin n_bad++; $display("FAIL gap_cnt: got %0d want 1", match_cnt); end
  endtask

  task automatic test_cfg_err();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      cfg_pattern = 8'b1; cfg_len = (k == 0) ? 4'd0 : 4'd9; cfg_overlap = 1;
      step(0, 0, 1, 1, 0);
      n_cmp++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL err_set[len=%0d]: got %b want 1", cfg_len, cfg_err); end
      for (int i = 0; i < 6; i++) begin
        step(0, 1'($urandom), 1, 0, 0);
        n_cmp++; if (obs_y !== 1'b0) begin n_bad++; $display("FAIL err_y[%0d]: got %b want 0", i, obs_y); end
      end
    end
    n_cmp++; if (match_cnt !== 8'd0) begin n_bad++; $display("FAIL err_cnt: got %0d want 0", match_cnt); end
    cfg_pattern = 8'hff; cfg_len = 8; cfg_overlap = 0;
    step(0, 0, 1, 1, 0);
    n_cmp++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", cfg_err); end
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 1, 0, 0);
      n_cmp++; if (obs_y !== (i == 7)) begin n_bad++; $display("FAIL maxlen_y[%0d]: got %b want %b", i, obs_y, (i == 7)); end
    end
  endtask

  task automatic test_saturation();
    bit [3:0] s = 4'b0111;
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 4; i++) step(0, s[3-i], 1, 0, 0);
    n_cmp++; if (cnt2 !== 2'd3) begin n_bad++; $display("FAIL sat_cnt2: got %0d want 3", cnt2); end
    n_cmp++; if (match_cnt !== 8'd5) begin n_bad++; $display("FAIL sat_cnt8: got %0d want 5", match_cnt); end
    for (int i = 0; i < 3; i++) step(0, s[3-i], 1, 0, 0);
    step(0, 1, 1, 0, 1);
    n_cmp++; if (obs_y2 !== 1'b1) begin n_bad++; $display("FAIL clr_match_y: got %b want 1", obs_y2); end
    n_cmp++; if (cnt2 !== 2'd0 || match_cnt !== 8'd0) begin n_bad++; $display("FAIL clr_cnt: got %0d/%0d want 0/0", cnt2, match_cnt); end
  endtask

  task automatic test_reset_mid();
    bit [3:0] s = 4'b0111;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, s[3-i], 1, 0, 0);
    step(1, 1, 1, 0, 0);
    n_cmp++; if (obs_y !== 1'b0) begin n_bad++; $display("FAIL midrst_during: got %b want 0", obs_y); end
    step(0, 1, 1, 0, 0);
    n_cmp++; if (obs_y !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got %b want 0", obs_y); end
    for (int i = 0; i < 4; i++) begin
      step(0, s[3-i], 1, 0, 0);
      n_cmp++; if (obs_y !== (i == 3)) begin n_bad++; $display("FAIL midrst_y[%0d]: got %b want %b", i, obs_y, (i == 3)); end
    end
  endtask

  task automatic test_random();
    bit r, l;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      l = ($urandom_range(0, 19) == 0);
      if (l) begin
        cfg_pattern = 8'($urandom);
        cfg_len = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(1, 4));
        cfg_overlap = 1'($urandom);
      end
      r = ($urandom_range(0, 99) == 0);
      step(r, 1'($urandom), $urandom_range(0, 3) != 0, l, $urandom_range(0, 29) == 0);
      n_cmp++; if (obs_y !== exp_y) begin n_bad++; $display("FAIL rand_y[%0d]: got %b want %b", i, obs_y, exp_y); end
      n_cmp++; if (match_cnt !== 8'(m_cnt) || cnt2 !== 2'(m_cnt2)) begin n_bad++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", i, match_cnt, cnt2, m_cnt, m_cnt2); end
      n_cmp++; if (cfg_err !== m_err) begin n_bad++; $display("FAIL rand_err[%0d]: got %b want %b", i, cfg_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_overlap();
    test_gaps();
    test_cfg_err();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Programmable serial pattern detector and the parametrised successor of the fixed 0111 detector. It watches a 1-bit serial stream and flags, in the same cycle, the bit that completes a run-time-loaded pattern of 1..MAX_LEN bits. It supports overlapping and non-overlapping match modes, an input-enable qualifier for gapped streams, and a saturating match counter. Out of reset it behaves as a 0111 non-overlapping detector, so it drops into existing test structures unchanged.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, $clog2(MAX_LEN+1), width of the length field
CNT_W, 8, width of the match counter
DEF_PATTERN, 'b0111, pattern loaded at reset (right-aligned; bit len-1 is the first bit received)
DEF_LEN, 4, pattern length loaded at reset
DEF_OVERLAP, 1'b0, overlap mode loaded at reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
d  in  1  serial data bit
en  in  1  d is valid this cycle
cfg_load  in  1  latch cfg_pattern, cfg_len and cfg_overlap this cycle
cfg_pattern  in  MAX_LEN  pattern, right-aligned, MSB-first order on the wire
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping matches allowed
cnt_clr  in  1  clear match_cnt
y  out  1  match: d completes the pattern this cycle (combinational, Mealy)
match_cnt  out  CNT_W  saturating count of matches
cfg_err  out  1  active configuration is illegal; detector disabled

Behaviour:
- Reset (sampled at posedge clk): pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, hist=0, fill=0, match_cnt=0, cfg_err=0.
  - y is 0 while reset is high.
- State:
  - hist: MAX_LEN-bit shift register of accepted bits.
  - fill: count of valid history bits, 0..MAX_LEN, saturating.
- Match (combinational): y = en & ~cfg_load & ~cfg_err & ~reset & (fill >= len-1) & ({hist[len-2:0], d} == pattern[len-1:0]).
  - Only the low len bits are compared; upper bits of pattern and hist are don't-care.
- Shift: on each en=1 cycle with cfg_load=0:
  - hist <= {hist[MAX_LEN-2:0], d}.
  - fill <= min(fill+1, MAX_LEN).
- en=0: hist, fill and match_cnt hold; y=0. Gaps are transparent.
- Non-overlap mode: when y=1, fill <= 0 instead of incrementing, so the next match needs len fresh bits.
- Overlap mode: when y=1, fill increments as normal, so the match tail can seed the next match.
- Config load (cfg_load=1): latch pattern, len and overlap; fill <= 0; hist holds; the d/en of that cycle is ignored; y=0.
  - cfg_err <= (cfg_len==0) | (cfg_len>MAX_LEN). While cfg_err=1, y=0, no shifting and no counting, until a legal load or reset.
  - cfg_len==1 is legal: y = en & (d==pattern[0]) with no history needed (fill>=0 always holds).
- Counter: match_cnt increments when y=1 and saturates at 2^CNT_W-1.
  - cnt_clr=1 forces match_cnt to 0 and has priority over a same-cycle increment.
- Priority: reset > cfg_load > normal operation. cnt_clr is independent of cfg_load.
- Reset asserted mid-pattern discards all partial history; config returns to defaults.
- Latency: y appears in the same cycle as the final pattern bit; match_cnt reflects it on the next cycle.

Test Plan:
- Default config after reset, d stream 0,1,1,1,0,1,1,1 (en=1) -> y=1 on cycles 4 and 8 only; match_cnt=2.
- Load pattern 'b101, len 3, overlap=1; stream 1,0,1,0,1 -> y=1 on bits 3 and 5. Same stream with overlap=0 -> y=1 on bit 3 only.
- Default config, stream 0,1,1,1 with en=0 bubbles between every bit -> y=1 only on the 4th valid bit; y=0 on all bubble cycles.
- cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err=1, y stays 0 for any stream. Then load len=MAX_LEN with pattern all-ones and feed MAX_LEN ones -> cfg_err=0, y=1 on the MAX_LEN-th one.
- CNT_W=2 with 5 matches -> match_cnt saturates at 3. cnt_clr asserted on the cycle of the next match -> match_cnt=0.
- Feed 0,1,1, assert reset for one cycle, then feed 1 -> y=0. Then 0,1,1,1 -> y=1 on the final bit.
